// File: rtl/seq_decoder.sv
// seq_decoder: multi-cycle Moore decoder. It fetches an instruction word, then an
// optional operand word, then runs an optional execute access. It drives the IP,
// IR, memory and raw-bus strobes, with a ready handshake, timed holds, a
// conditional branch, illegal-opcode flagging and recovery after a wait timeout.
module seq_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_CNT    = 2,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_ir,
    input  logic                  i_mem_ready,
    input  logic                  i_condition,
    output logic                  o_memory_address_source,
    output logic                  o_memory_read_enable,
    output logic                  o_memory_write_enable,
    output logic                  o_hold_ip_flag,
    output logic                  o_reset_ip,
    output logic                  o_select_jump_address,
    output logic                  o_ir_enable,
    output logic [BUS_CNT-1:0]    o_raw_bus_ren,
    output logic [BUS_CNT-1:0]    o_raw_bus_wen,
    output logic                  o_illegal,
    output logic                  o_timeout,
    output logic [2:0]            o_state
);

    localparam int ARG_W  = DATA_WIDTH - 4;
    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

    // Channel count widened by one bit so BUS_CNT == 2**ARG_W still compares correctly.
    localparam logic [ARG_W:0] BUS_CNT_L = BUS_CNT[ARG_W:0];
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    localparam logic [3:0] OP_RESET = 4'd0;
    localparam logic [3:0] OP_NOP   = 4'd1;
    localparam logic [3:0] OP_HOLD  = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_WRITE = 4'd4;
    localparam logic [3:0] OP_READ  = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;
    localparam logic [3:0] OP_BRAN  = 4'd7;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_OPERAND = 3'd3,
        S_EXEC    = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic [ARG_W-1:0]        hold_q, hold_d;
    logic [WCNT_W-1:0]       wait_q, wait_d;
    logic                    cond_q, cond_d;
    logic                    illegal_q, illegal_d;
    logic                    timeout_q, timeout_d;

    logic [3:0]              op_q;
    logic [ARG_W-1:0]        arg_q;
    logic                    chan_ok;
    logic                    illegal_op;
    logic                    in_access;
    logic                    bus_rd_any;
    logic                    bus_wr_any;

    // The channel number is the argument field of the latched instruction.
    assign op_q       = ir_q[DATA_WIDTH-1 -: 4];
    assign arg_q      = ir_q[ARG_W-1:0];
    assign chan_ok    = ({1'b0, arg_q} < BUS_CNT_L);
    assign illegal_op = op_q[3] ||
                        (((op_q == OP_LOAD) || (op_q == OP_WRITE) || (op_q == OP_READ)) && !chan_ok);
    assign in_access  = (state_q == S_FETCH) || (state_q == S_OPERAND) || (state_q == S_EXEC);

    // State and datapath registers; reset forces S_RESET immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            ir_q      <= '0;
            hold_q    <= '0;
            wait_q    <= '0;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic, including hold countdown and the wait-limit watchdog.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        hold_d    = hold_q;
        cond_d    = cond_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        wait_d    = '0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready) begin
                    ir_d    = i_ir;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cond_d = i_condition;
                if (illegal_op) begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    case (op_q)
                        OP_RESET: state_d = S_RESET;
                        OP_NOP:   state_d = S_FETCH;
                        OP_HOLD: begin
                            if (arg_q == '0) begin
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_HOLD;
                                hold_d  = arg_q;
                            end
                        end
                        default:  state_d = S_OPERAND;
                    endcase
                end
            end
            S_OPERAND: begin
                if (i_mem_ready) begin
                    state_d = ((op_q == OP_WRITE) || (op_q == OP_READ)) ? S_EXEC : S_FETCH;
                end
            end
            S_EXEC: begin
                if (i_mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == ARG_W'(1)) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
        // A completed access always leaves the state, so the counter restarts from zero.
        if (in_access && !i_mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                state_d   = S_RESET;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    // Moore output decode from state, latched opcode and latched condition.
    always_comb begin
        o_memory_address_source = 1'b0;
        o_memory_read_enable    = 1'b0;
        o_memory_write_enable   = 1'b0;
        o_hold_ip_flag          = 1'b0;
        o_reset_ip              = 1'b0;
        o_select_jump_address   = 1'b0;
        o_ir_enable             = 1'b0;
        bus_rd_any              = 1'b0;
        bus_wr_any              = 1'b0;
        case (state_q)
            S_RESET: o_reset_ip = 1'b1;
            S_FETCH: begin
                o_memory_read_enable = 1'b1;
                o_ir_enable          = 1'b1;
            end
            S_DECODE: o_hold_ip_flag = 1'b1;
            S_OPERAND: begin
                o_memory_read_enable = 1'b1;
                case (op_q)
                    OP_LOAD:           bus_rd_any            = 1'b1;
                    OP_WRITE, OP_READ: o_ir_enable           = 1'b1;
                    OP_JUMP:           o_select_jump_address = 1'b1;
                    OP_BRAN:           o_select_jump_address = cond_q;
                    default:           ;
                endcase
            end
            S_EXEC: begin
                o_memory_address_source = 1'b1;
                o_hold_ip_flag          = 1'b1;
                if (op_q == OP_WRITE) begin
                    o_memory_write_enable = 1'b1;
                    bus_wr_any            = 1'b1;
                end else if (op_q == OP_READ) begin
                    o_memory_read_enable = 1'b1;
                    bus_rd_any           = 1'b1;
                end
            end
            S_HOLD: o_hold_ip_flag = 1'b1;
            default: ;
        endcase
    end

    // One-hot channel strobes; an out-of-range channel never reaches a bus state.
    generate
        for (genvar gi = 0; gi < BUS_CNT; gi++) begin : g_bus
            assign o_raw_bus_ren[gi] = bus_rd_any && (arg_q == ARG_W'(gi));
            assign o_raw_bus_wen[gi] = bus_wr_any && (arg_q == ARG_W'(gi));
        end
    endgenerate

    assign o_illegal = illegal_q;
    assign o_timeout = timeout_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: directed test-plan steps followed by random instructions. Every
// cycle's outputs are checked against a transaction-level reference model that
// expands each instruction into its expected per-cycle output trace.
module tb_seq_decoder;

    localparam int DW = 8;
    localparam int BC = 2;
    localparam int WL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_ir = '0;
    logic          i_mem_ready = 1'b0;
    logic          i_condition = 1'b0;
    logic          o_memory_address_source;
    logic          o_memory_read_enable;
    logic          o_memory_write_enable;
    logic          o_hold_ip_flag;
    logic          o_reset_ip;
    logic          o_select_jump_address;
    logic          o_ir_enable;
    logic [BC-1:0] o_raw_bus_ren;
    logic [BC-1:0] o_raw_bus_wen;
    logic          o_illegal;
    logic          o_timeout;
    logic [2:0]    o_state;

    seq_decoder #(.DATA_WIDTH(DW), .BUS_CNT(BC), .WAIT_LIMIT(WL)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_ir                    (i_ir),
        .i_mem_ready             (i_mem_ready),
        .i_condition             (i_condition),
        .o_memory_address_source (o_memory_address_source),
        .o_memory_read_enable    (o_memory_read_enable),
        .o_memory_write_enable   (o_memory_write_enable),
        .o_hold_ip_flag          (o_hold_ip_flag),
        .o_reset_ip              (o_reset_ip),
        .o_select_jump_address   (o_select_jump_address),
        .o_ir_enable             (o_ir_enable),
        .o_raw_bus_ren           (o_raw_bus_ren),
        .o_raw_bus_wen           (o_raw_bus_wen),
        .o_illegal               (o_illegal),
        .o_timeout               (o_timeout),
        .o_state                 (o_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          src;
        logic          rd;
        logic          wr;
        logic          hold;
        logic          rip;
        logic          sj;
        logic          ire;
        logic [BC-1:0] bren;
        logic [BC-1:0] bwen;
        logic          ill;
        logic          to;
    } outs_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic pend_ill = 1'b0;
    logic pend_to  = 1'b0;

    function automatic outs_t blank(input logic [2:0] st);
        outs_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic outs_t reset_vec();
        outs_t e;
        e     = blank(3'd0);
        e.rip = 1'b1;
        return e;
    endfunction

    task automatic check_now(input string tag, input outs_t e);
        outs_t obs;
        obs.st   = o_state;
        obs.src  = o_memory_address_source;
        obs.rd   = o_memory_read_enable;
        obs.wr   = o_memory_write_enable;
        obs.hold = o_hold_ip_flag;
        obs.rip  = o_reset_ip;
        obs.sj   = o_select_jump_address;
        obs.ire  = o_ir_enable;
        obs.bren = o_raw_bus_ren;
        obs.bwen = o_raw_bus_wen;
        obs.ill  = o_illegal;
        obs.to   = o_timeout;
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %b required %b (st,src,rd,wr,hold,rip,sj,ire,bren,bwen,ill,to)",
                   tag, $time, obs, e);
        end
    endtask

    // One clock: check this cycle's outputs at the falling edge, then drive inputs.
    task automatic step(input string tag, input outs_t e, input logic [DW-1:0] ir,
                        input logic rdy, input logic cnd);
        @(negedge clk);
        e.ill    = pend_ill;
        e.to     = pend_to;
        pend_ill = 1'b0;
        pend_to  = 1'b0;
        check_now(tag, e);
        i_ir        = ir;
        i_mem_ready = rdy;
        i_condition = cnd;
    endtask

    task automatic reset_cycle();
        step("reset", reset_vec(), DW'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // A memory access that completes after 'delay' not-ready cycles, or times out.
    task automatic access(input string tag, input outs_t e, input int delay,
                          input logic [DW-1:0] data, output bit timed_out);
        timed_out = 1'b0;
        for (int k = 0; k < WL; k++) begin
            if (k == delay) begin
                step(tag, e, data, 1'b1, 1'($urandom));
                return;
            end
            step(tag, e, DW'($urandom), 1'b0, 1'($urandom));
        end
        timed_out = 1'b1;
        pend_to   = 1'b1;
    endtask

    // Reference model for one instruction: expands it into its expected cycle trace.
    task automatic instr(input logic [DW-1:0] w, input logic cnd, input int df,
                         input int dop, input int dex, input logic [DW-1:0] opnd);
        outs_t      e;
        bit         to;
        logic [3:0] op;
        logic [3:0] arg;
        bit         ill;
        op  = w[7:4];
        arg = w[3:0];
        ill = (op >= 4'd8) || ((op >= 4'd3) && (op <= 4'd5) && (int'(arg) >= BC));
        e     = blank(3'd1);
        e.rd  = 1'b1;
        e.ire = 1'b1;
        access("fetch", e, df, w, to);
        if (to) begin
            reset_cycle();
            return;
        end
        e      = blank(3'd2);
        e.hold = 1'b1;
        step("decode", e, DW'($urandom), 1'($urandom), cnd);
        if (ill) begin
            pend_ill = 1'b1;
            return;
        end
        if (op == 4'd0) begin
            reset_cycle();
            return;
        end
        if (op == 4'd1) return;
        if (op == 4'd2) begin
            for (int k = 0; k < int'(arg); k++) begin
                e      = blank(3'd5);
                e.hold = 1'b1;
                step("hold", e, DW'($urandom), 1'($urandom), 1'($urandom));
            end
            return;
        end
        e    = blank(3'd3);
        e.rd = 1'b1;
        case (op)
            4'd3:       e.bren = BC'(1 << arg);
            4'd4, 4'd5: e.ire  = 1'b1;
            4'd6:       e.sj   = 1'b1;
            default:    e.sj   = cnd;
        endcase
        access("operand", e, dop, opnd, to);
        if (to) begin
            reset_cycle();
            return;
        end
        if ((op == 4'd4) || (op == 4'd5)) begin
            e      = blank(3'd4);
            e.src  = 1'b1;
            e.hold = 1'b1;
            if (op == 4'd4) begin
                e.wr   = 1'b1;
                e.bwen = BC'(1 << arg);
            end else begin
                e.rd   = 1'b1;
                e.bren = BC'(1 << arg);
            end
            access("exec", e, dex, DW'($urandom), to);
            if (to) reset_cycle();
        end
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return r % 3;
        if (r < 19) return int'($urandom_range(3, WL - 1));
        return WL;
    endfunction

    initial begin
        outs_t e;
        // Reset held, then one full cycle of S_RESET after release.
        rst_n = 1'b0;
        step("in_reset", reset_vec(), '0, 1'b0, 1'b0);
        step("in_reset", reset_vec(), '0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        reset_cycle();

        // Directed steps.
        instr(8'h31, 1'b0, 0, 0, 0, 8'hA5);        // LOAD_BUS ch1
        instr(8'h40, 1'b0, 0, 0, 2, 8'h80);        // WRITE_BUS ch0, exec ready late
        instr(8'h51, 1'b1, 1, 1, 1, 8'h44);        // READ_BUS ch1
        instr(8'h70, 1'b1, 0, 0, 0, 8'h10);        // BRANCH taken
        instr(8'h70, 1'b0, 0, 0, 0, 8'h10);        // BRANCH not taken
        instr(8'h60, 1'b0, 0, 2, 0, 8'h22);        // JUMP
        instr(8'h23, 1'b0, 0, 0, 0, 8'h00);        // HOLD 3
        instr(8'h20, 1'b0, 0, 0, 0, 8'h00);        // HOLD 0
        instr(8'h93, 1'b0, 0, 0, 0, 8'h00);        // illegal opcode
        instr(8'h32, 1'b0, 0, 0, 0, 8'h00);        // illegal channel
        instr(8'h10, 1'b0, WL - 1, 0, 0, 8'h00);   // ready on the limit cycle wins
        instr(8'h10, 1'b0, WL, 0, 0, 8'h00);       // fetch timeout
        instr(8'h40, 1'b0, 0, 0, WL, 8'h00);       // exec timeout
        instr(8'h00, 1'b0, 0, 0, 0, 8'h00);        // RESET opcode

        // Asynchronous reset in the middle of an exec wait.
        instr(8'h10, 1'b0, 0, 0, 0, 8'h00);
        e     = blank(3'd1);
        e.rd  = 1'b1;
        e.ire = 1'b1;
        step("fetch", e, 8'h41, 1'b1, 1'b0);
        e      = blank(3'd2);
        e.hold = 1'b1;
        step("decode", e, 8'h00, 1'b0, 1'b0);
        e    = blank(3'd3);
        e.rd = 1'b1;
        e.ire = 1'b1;
        step("operand", e, 8'h80, 1'b1, 1'b0);
        e      = blank(3'd4);
        e.src  = 1'b1;
        e.hold = 1'b1;
        e.wr   = 1'b1;
        e.bwen = 2'b10;
        step("exec", e, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", reset_vec());
        @(posedge clk);
        #1 rst_n = 1'b1;
        reset_cycle();

        // Random instructions.
        for (int n = 0; n < 150; n++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            instr(w, 1'($urandom), rand_delay(), rand_delay(), rand_delay(), DW'($urandom));
        end
        e     = blank(3'd1);
        e.rd  = 1'b1;
        e.ire = 1'b1;
        step("final_fetch", e, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
Multi-cycle, parametrised successor to the single-cycle instruction decoder. It is a Moore FSM that fetches an instruction word, then fetches an optional operand word, then runs an execute access. It drives the same IP, memory and IR control strobes as today, but for BUS_CNT raw-bus channels. It adds a memory-ready handshake, timed holds, conditional branch, illegal-opcode flagging and a wait-timeout recovery. It sits between the memory data port (instruction/operand source) and the IP, IR, address and raw-bus register files.

Parameters:
DATA_WIDTH, 8, instruction/operand word width; opcode = ir[DATA_WIDTH-1:DATA_WIDTH-4], arg = ir[DATA_WIDTH-5:0].
BUS_CNT, 2, number of raw-bus channels; must satisfy BUS_CNT <= 2**(DATA_WIDTH-4).
WAIT_LIMIT, 16, maximum cycles to wait for i_mem_ready in any access state (>=1).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
i_ir  input  DATA_WIDTH  memory read data (instruction or operand word).
i_mem_ready  input  1  memory access completes this cycle.
i_condition  input  1  branch condition from datapath.
o_memory_address_source  output  1  0 = IP, 1 = operand address register.
o_memory_read_enable  output  1  memory read request.
o_memory_write_enable  output  1  memory write request.
o_hold_ip_flag  output  1  IP must not advance when an access completes.
o_reset_ip  output  1  clear IP.
o_select_jump_address  output  1  IP loads i_ir (jump target) instead of incrementing.
o_ir_enable  output  1  IR / operand-address register captures i_ir.
o_raw_bus_ren  output  BUS_CNT  channel n captures memory read data.
o_raw_bus_wen  output  BUS_CNT  channel n drives memory write data.
o_illegal  output  1  one-cycle pulse: illegal opcode or channel.
o_timeout  output  1  one-cycle pulse: wait limit exceeded.
o_state  output  3  current FSM state (debug).

Behaviour:
- Opcodes: 0 RESET; 1 NOP; 2 HOLD(arg = cycles); 3 LOAD_BUS(arg = ch); 4 WRITE_BUS(arg = ch); 5 READ_BUS(arg = ch); 6 JUMP; 7 BRANCH. Opcodes 8-15 are illegal. For opcodes 3/4/5, an arg >= BUS_CNT is illegal.
- States and encodings: S_RESET=0, S_FETCH=1, S_DECODE=2, S_OPERAND=3, S_EXEC=4, S_HOLD=5.
- All outputs are decoded from registered state, latched opcode/channel and latched condition only. No input reaches an output combinationally.
- rst_n low: state goes to S_RESET immediately (async). reg_ir, channel, hold counter, wait counter, condition latch, o_illegal and o_timeout all clear to 0.
- Output values in S_RESET: o_reset_ip=1, all other outputs 0, o_state=0.
- S_RESET: o_reset_ip=1 for exactly one clk after rst_n deasserts, then go to S_FETCH.
- S_FETCH: read_enable=1, ir_enable=1, address_source=0.
  - On i_mem_ready: latch i_ir into reg_ir and go to S_DECODE. IP advances.
- S_DECODE (1 cycle): hold_ip=1, no access. Latch i_condition. Next state:
  - RESET -> S_RESET.
  - NOP -> S_FETCH.
  - HOLD with arg=0 -> S_FETCH.
  - HOLD with arg>0 -> S_HOLD, counter loaded with arg.
  - Opcodes 3-7 -> S_OPERAND.
  - Illegal -> S_FETCH, and o_illegal pulses on the next cycle.
- S_OPERAND: read_enable=1, address_source=0. Per opcode:
  - LOAD_BUS: raw_bus_ren[ch]=1; on ready -> S_FETCH.
  - WRITE_BUS / READ_BUS: ir_enable=1; on ready -> S_EXEC.
  - JUMP: select_jump=1; on ready -> S_FETCH.
  - BRANCH: select_jump equals the latched condition; on ready -> S_FETCH (IP increments past the operand if not taken).
- S_EXEC: address_source=1, hold_ip=1. Per opcode:
  - WRITE_BUS: write_enable=1, raw_bus_wen[ch]=1.
  - READ_BUS: read_enable=1, raw_bus_ren[ch]=1.
  - On ready -> S_FETCH.
- S_HOLD: hold_ip=1, no access. Counter decrements each cycle; when it reaches 1 -> S_FETCH. Total time in S_HOLD = arg cycles.
- Wait counter:
  - Clears on every state entry.
  - Increments each cycle in S_FETCH, S_OPERAND or S_EXEC while i_mem_ready=0.
  - On reaching WAIT_LIMIT with i_mem_ready still 0: go to S_RESET and pulse o_timeout the next cycle.
  - If i_mem_ready=1 in the same cycle the limit is reached, ready wins and no timeout occurs.
- Per-opcode access count: exactly one access completes per fetch, operand and exec state. Bus strobes are one-hot or zero.

Test Plan:
1. Release rst_n -> o_reset_ip=1 for 1 cycle; S_FETCH with read_enable=1 and ir_enable=1; o_state sequence 0,1.
2. Fetch 0x31 (LOAD_BUS ch1), then operand 0xA5, i_mem_ready=1 each cycle -> o_raw_bus_ren=2'b10 for 1 cycle in S_OPERAND; back to S_FETCH after 3 cycles total.
3. Fetch 0x40, then operand address 0x80, i_mem_ready delayed 2 cycles in S_EXEC -> address_source=1, write_enable=1, raw_bus_wen=2'b01 for 3 cycles, hold_ip=1.
4. Fetch 0x70 with i_condition=1, then with i_condition=0 -> select_jump=1 in S_OPERAND for the first case and 0 for the second.
5. Fetch 0x23 -> hold_ip=1 for 1 decode cycle + 3 hold cycles. Fetch 0x93 -> o_illegal=1 for 1 cycle. Fetch 0x32 (ch2 >= BUS_CNT) -> o_illegal=1, no bus strobe.
6. i_mem_ready held 0 in S_FETCH -> o_timeout pulses after 16 cycles, state goes to S_RESET. Pull rst_n low mid-S_EXEC -> all strobes drop at once and o_reset_ip=1.
